ifetch_queue: RTL

//  Instruction prefetch queue between the PC/instruction memory and the IF_ID pipe register.
//  - Fetches sequential words from a variable-latency instruction memory.
//  - Buffers them with their pc+4, in the same {pc_add_4, instruction} pairing the IF_ID register carries.
//  - Flushes all state and restarts fetch at a new PC when the MEM stage resolves a taken branch.

---
 rtl/ifetch_queue.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue feeding IF_ID with {pc+4, instruction} pairs from a variable-latency memory.
// Optional same-cycle bypass of an empty queue is enabled by defining IFQ_BYPASS_EN.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic                         imem_req_o,
  output logic [31:0]                  imem_addr_o,
  input  logic                         imem_ack_i,
  input  logic [31:0]                  imem_data_i,
  output logic                         deq_valid_o,
  input  logic                         deq_ready_i,
  output logic [31:0]                  deq_instr_o,
  output logic [31:0]                  deq_pc_add_4_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   drop_addr, drop_addr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [CW-1:0] count_after;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc4_q   [DEPTH];

  logic          accept;
  logic          byp;
  logic          enq;
  logic          deq;
  logic          credit;
  logic [31:0]   pc_add_4;

  assign pc_add_4 = fetch_pc + 32'd4;

  always_comb begin
    accept = (state == REQ) && imem_ack_i && !redirect_i;
`ifdef IFQ_BYPASS_EN
    byp    = accept && (count == '0);
`else
    byp    = 1'b0;
`endif
    // A bypassed word taken by the consumer this cycle never occupies a slot.
    enq         = accept && !(byp && deq_ready_i);
    deq         = (count != '0) && deq_ready_i;
    count_after = count + CW'(enq) - CW'(deq);
    credit      = count_after < DEPTH_C;
  end

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    drop_addr_nxt = drop_addr;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count_after;

    case (state)
      IDLE:    if (credit) state_nxt = REQ;
      REQ:     if (imem_ack_i && !credit) state_nxt = IDLE;
      DROP:    if (imem_ack_i) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase

    if (enq) wr_ptr_nxt = wr_ptr + PW'(1);
    if (deq) rd_ptr_nxt = rd_ptr + PW'(1);
    if (accept) fetch_pc_nxt = pc_add_4;

    // An unacked request must run to completion at its original address,
    // so it is parked in DROP and its eventual ack swallowed.
    if (redirect_i) begin
      fetch_pc_nxt = redirect_pc_i & 32'hFFFF_FFFC;
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      count_nxt    = '0;
      if ((state == REQ || state == DROP) && !imem_ack_i) begin
        state_nxt = DROP;
        if (state == REQ) drop_addr_nxt = fetch_pc;
      end else begin
        state_nxt = REQ;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      drop_addr <= drop_addr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && enq) begin
      instr_q[wr_ptr] <= imem_data_i;
      pc4_q[wr_ptr]   <= pc_add_4;
    end
  end

  assign imem_req_o  = (state != IDLE);
  assign imem_addr_o = (state == DROP) ? drop_addr : fetch_pc;
  assign count_o     = count;

  always_comb begin
    deq_valid_o    = 1'b0;
    deq_instr_o    = '0;
    deq_pc_add_4_o = '0;
    if (count != '0) begin
      deq_valid_o    = 1'b1;
      deq_instr_o    = instr_q[rd_ptr];
      deq_pc_add_4_o = pc4_q[rd_ptr];
    end else if (byp) begin
      deq_valid_o    = 1'b1;
      deq_instr_o    = imem_data_i;
      deq_pc_add_4_o = pc_add_4;
    end
  end

endmodule
